// File: rtl/panel_select.sv
// Front-panel antenna selection: synchronises and debounces two banks of
// active-low buttons, keeps one-hot selections per radio and strobes the latch.
module panel_select #(
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = 16,
  parameter int LOAD_W     = 2
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic [5:0] I_btn_A,
  input  logic [5:0] I_btn_B,
  input  logic       I_remote,
  output logic [5:0] O_A,
  output logic [5:0] O_B,
  output logic       O_collision,
  output logic       O_load
);

  localparam logic [5:0]       RELEASED   = 6'b111111;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEB_CYCLES - 1);
  localparam int               PW         = (LOAD_W > 1) ? $clog2(LOAD_W) : 1;
  localparam logic [PW-1:0]    PULSE_LAST = PW'(LOAD_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    PULSE  = 2'd2
  } state_t;

  logic [1:0][5:0] btn_raw;
  logic [1:0]      evt;
  logic [1:0][2:0] evt_idx;
  logic [1:0]      req;
  logic [1:0][2:0] req_idx;
  logic [1:0][5:0] next_sel;

  state_t          state_reg;
  logic [PW-1:0]   pcnt_reg;
  logic [1:0][5:0] sel_reg;
  logic            collision_reg;
  logic            load_reg;
  logic [1:0]      pend_vld_reg;
  logic [1:0][2:0] pend_idx_reg;

  assign btn_raw[0] = I_btn_A;
  assign btn_raw[1] = I_btn_B;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [5:0]       sync1_reg;
      logic [5:0]       sync2_reg;
      logic [5:0]       cand_reg;
      logic [5:0]       stable_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             commit;
      logic             onecold;
      logic [5:0]       pressed;
      logic [2:0]       idx;

      always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
          sync1_reg  <= RELEASED;
          sync2_reg  <= RELEASED;
          cand_reg   <= RELEASED;
          stable_reg <= RELEASED;
          cnt_reg    <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != cand_reg) begin
            cand_reg <= sync2_reg;
            cnt_reg  <= '0;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (commit) begin
            stable_reg <= cand_reg;
          end
        end
      end

      // Candidate is accepted once it has held for the full debounce window.
      assign commit  = (sync2_reg == cand_reg) && (cnt_reg == CNT_MAX);
      assign pressed = ~cand_reg;
      assign onecold = (pressed != 6'd0) && ((pressed & (pressed - 6'd1)) == 6'd0);

      always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
          if (pressed[i]) begin
            idx = 3'(i);
          end
        end
      end

      // Only a clean single press from the fully released state is an event.
      assign evt[gi]     = commit && onecold && (stable_reg == RELEASED);
      assign evt_idx[gi] = idx;

      assign req[gi]      = evt[gi] | pend_vld_reg[gi];
      assign req_idx[gi]  = evt[gi] ? evt_idx[gi] : pend_idx_reg[gi];
      assign next_sel[gi] = sel_reg[gi][req_idx[gi]] ? 6'b000000
                                                      : (6'b000001 << req_idx[gi]);
    end
  endgenerate

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_reg     <= IDLE;
      pcnt_reg      <= '0;
      sel_reg       <= '0;
      collision_reg <= 1'b0;
      load_reg      <= 1'b0;
      pend_vld_reg  <= '0;
      pend_idx_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!I_remote && (req != 2'b00)) begin
            for (int b = 0; b < 2; b++) begin
              if (req[b]) begin
                sel_reg[b] <= next_sel[b];
              end
            end
            collision_reg <= |((req[0] ? next_sel[0] : sel_reg[0]) &
                               (req[1] ? next_sel[1] : sel_reg[1]));
            pend_vld_reg  <= '0;
            state_reg     <= SETTLE;
          end
        end
        SETTLE: begin
          load_reg  <= 1'b1;
          pcnt_reg  <= '0;
          state_reg <= PULSE;
        end
        PULSE: begin
          if (pcnt_reg == PULSE_LAST) begin
            load_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            pcnt_reg <= pcnt_reg + 1'b1;
          end
        end
        default: begin
          load_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase

      // Remote ownership drops queued presses; otherwise park events seen mid-strobe.
      if (I_remote) begin
        pend_vld_reg <= '0;
      end else if (state_reg != IDLE) begin
        for (int b = 0; b < 2; b++) begin
          if (evt[b]) begin
            pend_vld_reg[b] <= 1'b1;
            pend_idx_reg[b] <= evt_idx[b];
          end
        end
      end
    end
  end

  assign O_A         = sel_reg[0];
  assign O_B         = sel_reg[1];
  assign O_collision = collision_reg;
  assign O_load      = load_reg;

endmodule

// File: tb/tb_panel_select.sv
// Directed bench for panel_select: vector table for press/selection behaviour
// plus hand-written sequences for latency, bounce, pending and reset cases.
module tb_panel_select;

  localparam int DEB = 8;
  localparam int LW  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] btn_a = 6'b111111;
  logic [5:0] btn_b = 6'b111111;
  logic       remote = 1'b0;
  logic [5:0] O_A;
  logic [5:0] O_B;
  logic       O_collision;
  logic       O_load;

  always #5 clk = ~clk;

  panel_select #(
    .DEB_CYCLES(DEB),
    .CNT_W     (4),
    .LOAD_W    (LW)
  ) dut (
    .I_clk      (clk),
    .I_rst_n    (rst_n),
    .I_btn_A    (btn_a),
    .I_btn_B    (btn_b),
    .I_remote   (remote),
    .O_A        (O_A),
    .O_B        (O_B),
    .O_collision(O_collision),
    .O_load     (O_load)
  );

  int         checks = 0;
  int         errors = 0;
  int         strobe_total = 0;
  logic       load_prev = 1'b0;
  logic [5:0] cap_a [64];
  logic [5:0] cap_b [64];

  // Count strobes and capture the data presented at each rising load edge.
  always @(negedge clk) begin
    if (O_load && !load_prev) begin
      cap_a[strobe_total % 64] = O_A;
      cap_b[strobe_total % 64] = O_B;
      strobe_total = strobe_total + 1;
    end
    load_prev = O_load;
  end

  typedef struct {
    string      nm;
    logic [5:0] a;
    logic [5:0] b;
    logic       rem;
    logic [5:0] ea;
    logic [5:0] eb;
    logic       ec;
    int         es;
  } vec_t;

  vec_t vt [9];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end else begin
      $display("ok   %s value=%0h", nm, act);
    end
  endtask

  task automatic wait_sel(input int limit, output int n);
    logic [5:0] a0;
    logic [5:0] b0;
    a0 = O_A;
    b0 = O_B;
    n  = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (O_A !== a0 || O_B !== b0) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s;
    int found;

    vt[0] = '{"v0_a0_off",     6'b111110, 6'b111111, 1'b0, 6'b000000, 6'b000000, 1'b0, 1};
    vt[1] = '{"v1_a4",         6'b101111, 6'b111111, 1'b0, 6'b010000, 6'b000000, 1'b0, 1};
    vt[2] = '{"v2_b4_coll",    6'b111111, 6'b101111, 1'b0, 6'b010000, 6'b010000, 1'b1, 1};
    vt[3] = '{"v3_b1",         6'b111111, 6'b111101, 1'b0, 6'b010000, 6'b000010, 1'b0, 1};
    vt[4] = '{"v4_a3_b5",      6'b110111, 6'b011111, 1'b0, 6'b001000, 6'b100000, 1'b0, 1};
    vt[5] = '{"v5_multi",      6'b110110, 6'b111111, 1'b0, 6'b001000, 6'b100000, 1'b0, 0};
    vt[6] = '{"v6_remote_b0",  6'b111111, 6'b111110, 1'b1, 6'b001000, 6'b100000, 1'b0, 0};
    vt[7] = '{"v7_b5_off",     6'b111111, 6'b011111, 1'b0, 6'b001000, 6'b000000, 1'b0, 1};
    vt[8] = '{"v8_a0",         6'b111110, 6'b111111, 1'b0, 6'b000001, 6'b000000, 1'b0, 1};

    // Reset state and idle behaviour.
    rst_n = 1'b0;
    cyc(3);
    check("rst_A", 32'(O_A), 32'h0);
    check("rst_B", 32'(O_B), 32'h0);
    check("rst_coll", 32'(O_collision), 32'h0);
    check("rst_load", 32'(O_load), 32'h0);
    rst_n = 1'b1;
    cyc(50);
    check("idle_A", 32'(O_A), 32'h0);
    check("idle_B", 32'(O_B), 32'h0);
    check("idle_strobes", 32'(strobe_total), 32'h0);

    // Clean press of A bit 2: latency and strobe shape.
    s = strobe_total;
    btn_a = 6'b111011;
    wait_sel(30, n);
    check("press_latency_in_range", 32'((n >= DEB) && (n <= DEB + 4)), 32'h1);
    check("press_A", 32'(O_A), 32'h04);
    check("press_settle_load", 32'(O_load), 32'h0);
    cyc(1);
    check("press_pulse1_load", 32'(O_load), 32'h1);
    cyc(1);
    check("press_pulse2_load", 32'(O_load), 32'h1);
    cyc(1);
    check("press_after_load", 32'(O_load), 32'h0);
    cyc(10);
    check("press_strobes", 32'(strobe_total - s), 32'h1);
    btn_a = 6'b111111;
    cyc(25);
    check("release_strobes", 32'(strobe_total - s), 32'h1);
    check("release_A", 32'(O_A), 32'h04);

    // Bounce on A bit 0, then a steady press.
    s = strobe_total;
    for (int i = 0; i < 10; i++) begin
      btn_a[0] = ~btn_a[0];
      cyc(3);
    end
    btn_a[0] = 1'b0;
    check("bounce_strobes", 32'(strobe_total - s), 32'h0);
    check("bounce_A", 32'(O_A), 32'h04);
    wait_sel(30, n);
    check("bounce_latency_in_range", 32'((n >= DEB) && (n <= DEB + 4)), 32'h1);
    check("bounce_A_sel", 32'(O_A), 32'h01);
    cyc(10);
    check("bounce_one_strobe", 32'(strobe_total - s), 32'h1);
    btn_a = 6'b111111;
    cyc(25);

    // Vector table.
    for (int v = 0; v < 9; v++) begin
      s = strobe_total;
      btn_a  = vt[v].a;
      btn_b  = vt[v].b;
      remote = vt[v].rem;
      cyc(20);
      btn_a = 6'b111111;
      btn_b = 6'b111111;
      cyc(20);
      remote = 1'b0;
      check({vt[v].nm, "_A"}, 32'(O_A), 32'(vt[v].ea));
      check({vt[v].nm, "_B"}, 32'(O_B), 32'(vt[v].eb));
      check({vt[v].nm, "_coll"}, 32'(O_collision), 32'(vt[v].ec));
      check({vt[v].nm, "_strobes"}, 32'(strobe_total - s), 32'(vt[v].es));
    end

    // Simultaneous A/B events give a single strobe carrying both.
    s = strobe_total;
    btn_a = 6'b110111;
    btn_b = 6'b011111;
    cyc(20);
    btn_a = 6'b111111;
    btn_b = 6'b111111;
    cyc(20);
    check("same_cycle_strobes", 32'(strobe_total - s), 32'h1);
    check("same_cycle_cap_A", 32'(cap_a[s % 64]), 32'h08);
    check("same_cycle_cap_B", 32'(cap_b[s % 64]), 32'h20);

    // A event lands two cycles after B's, inside PULSE, and is deferred.
    s = strobe_total;
    btn_b = 6'b111110;
    cyc(2);
    btn_a = 6'b111101;
    wait_sel(30, n);
    check("pend_first_found", 32'(n > 0), 32'h1);
    check("pend_first_B", 32'(O_B), 32'h01);
    check("pend_first_A_held", 32'(O_A), 32'h08);
    cyc(25);
    check("pend_strobes", 32'(strobe_total - s), 32'h2);
    check("pend_cap0_A", 32'(cap_a[s % 64]), 32'h08);
    check("pend_cap0_B", 32'(cap_b[s % 64]), 32'h01);
    check("pend_cap1_A", 32'(cap_a[(s + 1) % 64]), 32'h02);
    check("pend_cap1_B", 32'(cap_b[(s + 1) % 64]), 32'h01);
    btn_a = 6'b111111;
    btn_b = 6'b111111;
    cyc(20);

    // Reset asserted mid-strobe after creating a collision on bit 1.
    btn_b = 6'b111101;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (O_load) begin
        found = 1;
        break;
      end
    end
    check("rst_mid_found_load", 32'(found), 32'h1);
    check("rst_mid_coll_before", 32'(O_collision), 32'h1);
    rst_n = 1'b0;
    btn_b = 6'b111111;
    cyc(1);
    check("rst_mid_load", 32'(O_load), 32'h0);
    check("rst_mid_A", 32'(O_A), 32'h0);
    check("rst_mid_B", 32'(O_B), 32'h0);
    check("rst_mid_coll", 32'(O_collision), 32'h0);
    rst_n = 1'b1;
    s = strobe_total;
    cyc(20);
    check("post_rst_strobes", 32'(strobe_total - s), 32'h0);
    check("post_rst_B", 32'(O_B), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/panel_select.md
Name: panel_select

Overview:
- Front-panel selection stage that sits directly upstream of the output latch.
- Synchronises and debounces two banks of six active-low antenna buttons, one bank per radio (A, B). It maintains one-hot antenna selections per radio and flags collisions, where A and B select the same antenna.
- Issues the load strobe that commits the selections into the output latch.
- Its outputs connect directly to the latch's A/B/load/collision inputs. I_remote is shared with the latch.

Parameters:
DEB_CYCLES, 50000, cycles a bank's synchronised button pattern must hold unchanged before it is accepted (>= 4)
CNT_W, 16, debounce counter width; must hold DEB_CYCLES-1
LOAD_W, 2, width of O_load pulse in cycles (>= 1)

Ports:
I_clk  input  1  system clock
I_rst_n  input  1  reset; synchronous to I_clk, active-low
I_btn_A  input  6  raw radio-A buttons, active-low (0 = pressed), asynchronous
I_btn_B  input  6  raw radio-B buttons, active-low, asynchronous
I_remote  input  1  HIGH = remote control owns the switch; panel ignored
O_A  output  6  radio-A selection, one-hot or zero, HIGH effective
O_B  output  6  radio-B selection, one-hot or zero, HIGH effective
O_collision  output  1  HIGH when O_A & O_B is nonzero
O_load  output  1  HIGH-effective load strobe; latch samples on rising edge

Behaviour:
- Reset (I_rst_n=0 at a rising I_clk edge):
  - O_A=0, O_B=0, O_collision=0, O_load=0.
  - Synchroniser and stable-pattern registers = 6'b111111 (released).
  - Counters = 0, pending flags = 0, FSM = IDLE.
  - Reset overrides everything; a pulse in progress is cut off immediately.
- Synchronisation: 2-FF synchroniser per button bit.
- Debounce, one counter per bank:
  - If the synchronised pattern differs from the candidate register: candidate <= pattern and counter <= 0.
  - Otherwise the counter increments, saturating at DEB_CYCLES-1.
  - On the cycle the counter reaches DEB_CYCLES-1: stable <= candidate.
- Press event for a bank: asserted for 1 cycle only when stable goes from 6'b111111 to a pattern with exactly one 0, at index k.
  - Transitions to multi-button patterns, releases, and changes between non-released patterns generate no event.
- Event application produces next_sel for the bank:
  - If sel[k] is already 1, next_sel = 0 (press again to disconnect).
  - Otherwise next_sel = one-hot(k).
- Remote mode:
  - While I_remote=1, events are discarded and pending flags are cleared.
  - The FSM completes any pulse in progress.
  - O_A and O_B hold their values.
- FSM:
  - IDLE:
    - If an event or pending exists on either bank: apply it, updating O_A/O_B and O_collision in the same register update, clear pending, and go to SETTLE.
    - Events on A and B in the same cycle are both applied and produce one strobe.
  - SETTLE: 1 cycle with O_load=0, so data is stable before the strobe edge. Next state is PULSE.
  - PULSE: O_load=1 for exactly LOAD_W cycles, then IDLE.
  - Events arriving in SETTLE or PULSE are stored in a per-bank pending slot (index plus valid; the latest overwrites). They are applied on the first IDLE cycle.
- O_collision = |(O_A & O_B), registered with O_A/O_B.
  - The strobe is still issued during a collision; the latch ignores it.
- Latency:
  - Event detected at cycle t.
  - O_A/O_B/O_collision change at t+1.
  - O_load is high for cycles t+2 .. t+1+LOAD_W.
  - FSM is back in IDLE at t+2+LOAD_W.
- Raw input to event: at most DEB_CYCLES+3 cycles after the last raw edge.

Test Plan:
Use DEB_CYCLES=8 and LOAD_W=2 for all scenarios.
1. Reset, then hold buttons released for 50 cycles -> O_A=O_B=0, O_collision=0, O_load never asserted.
2. Press A bit 2 (I_btn_A=6'b111011) cleanly, then release -> O_A=6'b000100 exactly 1 cycle after the event; O_load high 2 cycles starting the cycle after; one strobe total; release produces no strobe.
3. Bounce A bit 0 with a toggle every 3 cycles for 30 cycles, then hold pressed -> no event during bounce; a single event ~11 cycles after the last edge; O_A=6'b000001. A second clean press-release of bit 0 -> O_A=0 with a new strobe.
4. Select A=bit 4, then press B bit 4 -> O_B=6'b010000, O_collision=1, strobe issued. Then press B bit 1 -> O_B=6'b000010, O_collision=0.
5. Press A bit 3 and B bit 5 so their events land in the same cycle, then press A bit 1 timed so its event lands during PULSE -> first strobe carries A=6'b001000, B=6'b100000; A=6'b000010 is applied on return to IDLE followed by a second strobe.
6. Assert I_remote, press B bit 0 -> no change, no strobe. Also assert I_rst_n=0 while O_load=1 -> O_load=0 and all outputs 0 at the next edge.
